// File: rtl/dfr_sched_pkg.sv
// dfr_sched_pkg: shared state encoding and default widths/timeouts for the DFR batch scheduler.
package dfr_sched_pkg;

    localparam int DEF_ADDR_WIDTH     = 32;
    localparam int DEF_CNT_WIDTH      = 16;
    localparam int DEF_TIMEOUT_CYCLES = 65535;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_ADVANCE,
        S_FINISH,
        S_FAULT
    } sched_state_t;

endpackage

// File: rtl/dfr_sched_watchdog.sv
// dfr_sched_watchdog: counts cycles spent in a wait state; expired on the TIMEOUT_CYCLES-th cycle.
module dfr_sched_watchdog
    import dfr_sched_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expired = enable && (cnt_q >= CW'(TIMEOUT_CYCLES - 1));

    always_comb cnt_d = clear ? '0 : (enable && !expired) ? cnt_q + CW'(1) : cnt_q;

    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;

endmodule

// File: rtl/dfr_batch_scheduler.sv
// dfr_batch_scheduler: walks the DFR core over a batch of samples with per-wait watchdog and abort.
// Optional cycle_count output when DFR_SCHED_CYCLE_CNT_EN is defined.
module dfr_batch_scheduler
    import dfr_sched_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int CNT_WIDTH      = DEF_CNT_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [CNT_WIDTH-1:0]  num_samples,
    input  logic [ADDR_WIDTH-1:0] in_base,
    input  logic [ADDR_WIDTH-1:0] in_stride,
    input  logic [ADDR_WIDTH-1:0] out_base,
    input  logic [ADDR_WIDTH-1:0] out_stride,
    input  logic                  core_busy,
    output logic                  core_start,
    output logic                  core_rst,
    output logic [ADDR_WIDTH-1:0] core_in_addr,
    output logic [ADDR_WIDTH-1:0] core_out_addr,
    output logic [CNT_WIDTH-1:0]  sample_idx,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  aborted
`ifdef DFR_SCHED_CYCLE_CNT_EN
    ,
    output logic [31:0]           cycle_count
`endif
);

    sched_state_t          state_q, state_d;
    logic [CNT_WIDTH-1:0]  num_q, num_d, idx_q, idx_d, idx_nx;
    logic [ADDR_WIDTH-1:0] in_stride_q, in_stride_d, out_stride_q, out_stride_d;
    logic [ADDR_WIDTH-1:0] in_addr_q, in_addr_d, out_addr_q, out_addr_d;
    logic core_start_q, core_start_d, core_rst_q, core_rst_d, done_q, done_d;
    logic busy_q, busy_d, error_q, error_d, aborted_q, aborted_d;
    logic accept, wd_clear, wd_en, wd_expired;

    assign accept = (state_q == S_IDLE) && start && !abort;
    assign idx_nx = idx_q + CNT_WIDTH'(1);

    always_comb begin
        state_d      = state_q;
        num_d        = num_q;
        idx_d        = idx_q;
        in_stride_d  = in_stride_q;
        out_stride_d = out_stride_q;
        in_addr_d    = in_addr_q;
        out_addr_d   = out_addr_q;
        error_d      = error_q;
        aborted_d    = aborted_q;
        if (abort && state_q != S_IDLE && state_q != S_FAULT) begin
            state_d   = S_FAULT;
            aborted_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: if (accept) begin
                    num_d        = num_samples;
                    in_stride_d  = in_stride;
                    out_stride_d = out_stride;
                    in_addr_d    = in_base;
                    out_addr_d   = out_base;
                    idx_d        = '0;
                    error_d      = 1'b0;
                    aborted_d    = 1'b0;
                    state_d      = (num_samples == '0) ? S_FINISH : S_LAUNCH;
                end
                S_LAUNCH:    state_d = S_WAIT_ACK;
                S_WAIT_ACK:  state_d = core_busy ? S_WAIT_DONE : wd_expired ? S_FAULT : S_WAIT_ACK;
                S_WAIT_DONE: state_d = !core_busy ? S_ADVANCE : wd_expired ? S_FAULT : S_WAIT_DONE;
                S_ADVANCE: begin
                    idx_d      = idx_nx;
                    in_addr_d  = in_addr_q + in_stride_q;
                    out_addr_d = out_addr_q + out_stride_q;
                    state_d    = (idx_nx == num_q) ? S_FINISH : S_LAUNCH;
                end
                default: state_d = S_IDLE;
            endcase
            // Only a watchdog expiry can reach FAULT from a wait state on this path
            if (state_d == S_FAULT) error_d = 1'b1;
        end
        core_start_d = state_d == S_LAUNCH;
        core_rst_d   = state_d == S_FAULT;
        done_d       = state_d == S_FINISH;
        busy_d       = state_d != S_IDLE;
    end

    assign wd_en    = (state_q == S_WAIT_ACK) || (state_q == S_WAIT_DONE);
    assign wd_clear = ((state_d == S_WAIT_ACK) || (state_d == S_WAIT_DONE)) && (state_d != state_q);

    dfr_sched_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .enable  (wd_en),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            num_q        <= '0;
            idx_q        <= '0;
            in_stride_q  <= '0;
            out_stride_q <= '0;
            in_addr_q    <= '0;
            out_addr_q   <= '0;
            core_start_q <= 1'b0;
            core_rst_q   <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            error_q      <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            num_q        <= num_d;
            idx_q        <= idx_d;
            in_stride_q  <= in_stride_d;
            out_stride_q <= out_stride_d;
            in_addr_q    <= in_addr_d;
            out_addr_q   <= out_addr_d;
            core_start_q <= core_start_d;
            core_rst_q   <= core_rst_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            error_q      <= error_d;
            aborted_q    <= aborted_d;
        end
    end

    assign core_start    = core_start_q;
    assign core_rst      = core_rst_q;
    assign core_in_addr  = in_addr_q;
    assign core_out_addr = out_addr_q;
    assign sample_idx    = idx_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign aborted       = aborted_q;

`ifdef DFR_SCHED_CYCLE_CNT_EN
    logic [31:0] cyc_q, cyc_d;

    assign cyc_d = accept ? '0 : (busy_q && cyc_q != '1) ? cyc_q + 32'd1 : cyc_q;

    always_ff @(posedge clk or posedge rst)
        if (rst) cyc_q <= '0;
        else     cyc_q <= cyc_d;

    assign cycle_count = cyc_q;
`endif

endmodule

// File: tb/tb_dfr_batch_scheduler.sv
// tb_dfr_batch_scheduler: directed plus randomized batches against a per-batch expectation model.
module tb_dfr_batch_scheduler;

    localparam int AW = 32;
    localparam int CW = 16;
    localparam int TO = 12;

    typedef struct packed {
        logic [AW-1:0] ia;
        logic [AW-1:0] oa;
        logic [CW-1:0] idx;
    } launch_t;

    logic clk = 1'b0;
    logic rst, start, abort, core_busy;
    logic [CW-1:0] num_samples;
    logic [AW-1:0] in_base, in_stride, out_base, out_stride;
    logic core_start, core_rst, busy, done, error, aborted;
    logic [AW-1:0] core_in_addr, core_out_addr;
    logic [CW-1:0] sample_idx;
`ifdef DFR_SCHED_CYCLE_CNT_EN
    logic [31:0] cycle_count;
`endif

    int tests = 0, fails = 0;
    launch_t lq[$];
    int done_n, rst_n, busy_n, cyc, first_busy, done_at;
    int mode, fix_ack, fix_len, lat_sum;

    dfr_batch_scheduler #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .num_samples(num_samples),
        .in_base(in_base), .in_stride(in_stride), .out_base(out_base), .out_stride(out_stride),
        .core_busy(core_busy), .core_start(core_start), .core_rst(core_rst),
        .core_in_addr(core_in_addr), .core_out_addr(core_out_addr), .sample_idx(sample_idx),
        .busy(busy), .done(done), .error(error), .aborted(aborted)
`ifdef DFR_SCHED_CYCLE_CNT_EN
        , .cycle_count(cycle_count)
`endif
    );

    initial forever #5 clk = ~clk;

    // Monitor: logs every launch and counts pulses / busy cycles
    initial begin
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (core_start) lq.push_back(launch_t'({core_in_addr, core_out_addr, sample_idx}));
            if (done) begin done_n++; done_at = cyc; end
            if (core_rst) rst_n++;
            if (busy) begin if (busy_n == 0) first_busy = cyc; busy_n++; end
        end
    end

    // Core model: mode 0 random latencies, 1 fixed latencies, 2 never acknowledges
    initial begin
        core_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (core_start && mode != 2) begin
                int a, l;
                a = (mode == 1) ? fix_ack : int'($urandom_range(1, 3));
                l = (mode == 1) ? fix_len : int'($urandom_range(1, 8));
                lat_sum += a + l;
                repeat (a) @(negedge clk);
                core_busy = 1'b1;
                repeat (l) @(negedge clk);
                core_busy = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        lq.delete();
        done_n = 0; rst_n = 0; busy_n = 0; lat_sum = 0;
    endtask

    task automatic scramble_cfg();
        num_samples = CW'($urandom_range(0, 9));
        in_base = $urandom; in_stride = $urandom; out_base = $urandom; out_stride = $urandom;
    endtask

    task automatic go(input int n, input logic [AW-1:0] ib, input logic [AW-1:0] is,
                      input logic [AW-1:0] ob, input logic [AW-1:0] os, input bit mid);
        clear_mon();
        @(negedge clk);
        start = 1'b1; num_samples = CW'(n);
        in_base = ib; in_stride = is; out_base = ob; out_stride = os;
        @(negedge clk);
        start = 1'b0;
        scramble_cfg();
        if (mid) begin
            repeat (2) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        for (int i = 0; i < 4000 && busy; i++) @(negedge clk);
        chk("batch_end", 64'(busy), 64'd0);
        @(negedge clk);
    endtask

    // Expected results derived from the batch description alone
    task automatic verify(input string tag, input int n, input logic [AW-1:0] ib,
                          input logic [AW-1:0] is, input logic [AW-1:0] ob, input logic [AW-1:0] os);
        logic [AW-1:0] ei, eo;
        chk({tag, "_starts"}, 64'(lq.size()), 64'(n));
        for (int i = 0; i < n && i < lq.size(); i++) begin
            ei = ib + AW'(i) * is;
            eo = ob + AW'(i) * os;
            chk($sformatf("%s_in%0d", tag, i), 64'(lq[i].ia), 64'(ei));
            chk($sformatf("%s_out%0d", tag, i), 64'(lq[i].oa), 64'(eo));
            chk($sformatf("%s_idx%0d", tag, i), 64'(lq[i].idx), 64'(i));
        end
        chk({tag, "_done"}, 64'(done_n), 64'd1);
        chk({tag, "_corerst"}, 64'(rst_n), 64'd0);
        chk({tag, "_flags"}, {62'd0, error, aborted}, 64'd0);
        chk({tag, "_final_idx"}, 64'(sample_idx), 64'(n));
        chk({tag, "_busy_cyc"}, 64'(busy_n), 64'(lat_sum + 2 * n + 1));
`ifdef DFR_SCHED_CYCLE_CNT_EN
        chk({tag, "_cyc_cnt"}, 64'(cycle_count), 64'(busy_n));
`endif
    endtask

    initial begin
        logic [AW-1:0] ib, is, ob, os;
        int n;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        mode = 1; fix_ack = 1; fix_len = 1;
        num_samples = '0; in_base = '0; in_stride = '0; out_base = '0; out_stride = '0;
        clear_mon();
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {58'd0, busy, done, core_start, core_rst, error, aborted}, 64'd0);
        chk("rst_idx", 64'(sample_idx), 64'd0);
        chk("rst_addr", {core_in_addr, core_out_addr}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        mode = 1; fix_ack = 1; fix_len = 10;
        go(3, 32'h100, 32'h40, 32'h2000, 32'h80, 1'b0);
        verify("three", 3, 32'h100, 32'h40, 32'h2000, 32'h80);

        go(0, 32'h500, 32'h10, 32'h600, 32'h10, 1'b0);
        verify("zero", 0, 32'h500, 32'h10, 32'h600, 32'h10);
        chk("zero_done_when", 64'(done_at), 64'(first_busy));

        mode = 2;
        go(2, 32'h1000, 32'h8, 32'h3000, 32'h8, 1'b0);
        chk("to_corerst", 64'(rst_n), 64'd1);
        chk("to_error", 64'(error), 64'd1);
        chk("to_done", 64'(done_n), 64'd0);
        chk("to_starts", 64'(lq.size()), 64'd1);
        chk("to_busy_cyc", 64'(busy_n), 64'(TO + 2));
        mode = 0;
        go(2, 32'h40, 32'h4, 32'h80, 32'h4, 1'b0);
        verify("after_to", 2, 32'h40, 32'h4, 32'h80, 32'h4);

        mode = 1; fix_ack = 1; fix_len = 10;
        clear_mon();
        @(negedge clk);
        start = 1'b1; num_samples = 16'd4;
        in_base = 32'hA000; in_stride = 32'h10; out_base = 32'hB000; out_stride = 32'h20;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 200 && lq.size() < 2; i++) @(negedge clk);
        chk("ab_reach_s2", 64'(lq.size()), 64'd2);
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_corerst_next", {61'd0, core_rst, aborted, busy}, 64'd7);
        chk("ab_no_done", 64'(done), 64'd0);
        @(negedge clk);
        chk("ab_idle", {62'd0, busy, core_rst}, 64'd0);
        for (int i = 0; i < 50 && core_busy; i++) @(negedge clk);
        @(negedge clk);
        chk("ab_rst_cnt", 64'(rst_n), 64'd1);
        chk("ab_done_cnt", 64'(done_n), 64'd0);
        chk("ab_idx", 64'(sample_idx), 64'd1);
        chk("ab_flags", {62'd0, error, aborted}, 64'd1);
        mode = 0;
        go(1, 32'h0, 32'h0, 32'h4, 32'h0, 1'b0);
        verify("after_ab", 1, 32'h0, 32'h0, 32'h4, 32'h0);

        go(2, 32'hFFFF_FFC0, 32'h40, 32'h10, 32'h4, 1'b0);
        verify("wrap", 2, 32'hFFFF_FFC0, 32'h40, 32'h10, 32'h4);
        if (lq.size() == 2) chk("wrap_zero", 64'(lq[1].ia), 64'd0);

        clear_mon();
        @(negedge clk);
        start = 1'b1; abort = 1'b1; num_samples = 16'd3;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("sa_idle", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        chk("sa_no_launch", 64'(lq.size() + busy_n), 64'd0);

        go(4, 32'h7000, 32'h100, 32'h9000, 32'h200, 1'b1);
        verify("mid_start", 4, 32'h7000, 32'h100, 32'h9000, 32'h200);

        for (int k = 0; k < 8; k++) begin
            n = $urandom_range(1, 6);
            ib = $urandom; is = $urandom; ob = $urandom; os = $urandom;
            go(n, ib, is, ob, os, 1'($urandom_range(0, 1)));
            verify($sformatf("rnd%0d", k), n, ib, is, ob, os);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
